hazard_ctrl_seq: RTL and testbench
==================================

Name: hazard_ctrl_seq

Overview:
- Parametrised next-generation hazard controller for the 5-stage RV32I pipeline. It sits beside the datapath and drives forwarding selects, flushes and per-stage stalls.
- It adds a registered peripheral-transaction FSM with a timeout watchdog, configurable blocking of slow-peripheral stores, an x0 guard on load-use detection, and a sticky error flag.
- Forwarding and load-use logic stay combinational. Peripheral wait tracking is sequential.

Parameters:
- REG_AW, 5, register-index width.
- PERIPH_W, 4, width of the peripheral select code.
- SLOW_ID, 2, peripheral code that completes asynchronously (UART).
- STORE_BLOCK, 1, 1 = stores to SLOW_ID also stall until done; 0 = stores are posted.
- TO_W, 16, timeout counter width.
- TO_MAX, 16'hFFFF, cycles spent in WAIT before the access is aborted.

Ports:
- clk in 1: pipeline clock.
- rst_n in 1: asynchronous active-low reset.
- rs1_d, rs2_d in REG_AW: source registers in Decode.
- rs1_e, rs2_e, rd_e in REG_AW: sources and destination in Execute.
- rd_m, rd_w in REG_AW: destinations in Memory and Writeback.
- reg_write_m, reg_write_w in 1: writeback enables in Memory and Writeback.
- load_e in 1: instruction in Execute is a load (ResultSrc[0]).
- pc_src_e in 1: taken branch or jump resolved in Execute.
- periph_req in 1: Memory-stage instruction accesses a peripheral.
- periph_sel in PERIPH_W: peripheral code of that access.
- periph_store in 1: the access is a store (opcode bit 5).
- periph_done in 1: peripheral completion pulse.
- err_clr in 1: clears timeout_err.
- fwd_a_e, fwd_b_e out 2: 00 = register file, 01 = Writeback, 10 = Memory.
- flush_d, flush_e out 1: flush Decode / Execute.
- stall_f, stall_d, stall_e, stall_m, stall_w out 1: per-stage stalls.
- periph_busy out 1: FSM is in WAIT.
- timeout_err out 1: sticky, set when an access is aborted on timeout.

Behaviour:
- Reset (async, rst_n low): state = IDLE, timeout counter = 0, timeout_err = 0.
  - All outputs are combinational from state and inputs, so with idle inputs every stall and flush is 0 and fwd = 00.
- Forwarding, per source operand:
  - 10 if rs==rd_m, reg_write_m=1 and rs!=0.
  - Otherwise 01 if rs==rd_w, reg_write_w=1 and rs!=0.
  - Otherwise 00. Memory takes priority over Writeback.
- Load-use: lw_stall = load_e & (rd_e!=0) & (rs1_d==rd_e | rs2_d==rd_e). The rd_e!=0 guard is new.
- Slow-access qualifier: slow = periph_req & (periph_sel==SLOW_ID) & (~periph_store | STORE_BLOCK).
- FSM states:
  - IDLE: if slow & ~periph_done -> WAIT, counter cleared. If slow & periph_done in the same cycle, stay IDLE with no stall (zero-wait completion).
  - WAIT: counter increments each cycle.
    - On periph_done -> IDLE.
    - On counter==TO_MAX-1 without done -> IDLE and set timeout_err.
    - periph_done wins if both occur in the same cycle.
- pstall = (IDLE & slow & ~periph_done) | (WAIT & ~periph_done & ~timeout_hit).
  - The request cycle stalls combinationally, with no one-cycle bubble.
  - The done cycle releases the stall, and the pipeline advances on that edge.
- Stall outputs:
  - stall_e = stall_m = stall_w = pstall.
  - stall_f = stall_d = pstall | lw_stall.
- Flush outputs, with priority pstall > branch > load-use:
  - flush_d = pc_src_e & ~pstall.
  - flush_e = (pc_src_e | lw_stall) & ~pstall.
  - The Execute instruction is held, not flushed, while the back end is frozen.
- periph_busy = (state==WAIT).
- timeout_err:
  - Set on timeout, cleared by err_clr.
  - If both occur in the same cycle, set wins.
- Counter: saturates at TO_MAX-1 and never wraps. A TO_MAX of 0 or 1 is illegal and is flagged by an elaboration assertion.
- Reset mid-WAIT: immediate return to IDLE. Stalls drop asynchronously.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel codes FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The FSM state enum {IDLE, WAIT}.
  - The default SLOW_ID.
- One natural sub-module, periph_wait_fsm: FSM, timeout counter and error flag, producing pstall and periph_busy.
- Forwarding and flush/stall muxing stay in the top level.

Test Plan:
- rs1_e=5, rd_m=5, reg_write_m=1, and also rd_w=5, reg_write_w=1 -> fwd_a_e=10. With rs1_e=0 -> fwd_a_e=00.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1, flush_d=0 for one cycle. Same with rd_e=0 -> all 0.
- periph_req=1, periph_sel=2, periph_store=0, periph_done after 4 cycles -> all five stalls high for 4 cycles, low in the done cycle, periph_busy high for cycles 2..4.
- Slow load with pc_src_e=1 during WAIT -> flush_d=flush_e=0 while pstall is high. Flushes assert in the first cycle after done if pc_src_e is still 1.
- TO_MAX=8, no periph_done -> stall released after 8 cycles, timeout_err=1 and held. err_clr pulse -> 0.
- STORE_BLOCK=0, slow store -> no stall. rst_n low mid-WAIT -> stalls 0 immediately, periph_busy=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forwarding codes, peripheral FSM states and defaults for the hazard controller
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int SLOW_ID_DEF = 2;
  typedef enum logic {IDLE, WAIT} periph_state_t;
endpackage

// File: rtl/periph_wait_fsm.sv
// periph_wait_fsm: tracks a slow peripheral access, aborts it on timeout and keeps a sticky error flag
module periph_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TO_W = 16,
  parameter logic [TO_W-1:0] TO_MAX = 16'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_slow,
  input  logic i_done,
  input  logic i_err_clr,
  output logic o_pstall,
  output logic o_busy,
  output logic o_timeout_err
);
  if (TO_MAX < 2) begin : g_bad_to_max
    $error("periph_wait_fsm: TO_MAX must be at least 2");
  end
  localparam logic [TO_W-1:0] CNT_LAST = TO_MAX - 1'b1;
  periph_state_t r_state;
  logic [TO_W-1:0] r_cnt;
  logic r_err;
  logic w_wait, w_to_hit;
  assign w_wait   = (r_state == WAIT);
  assign w_to_hit = w_wait & (r_cnt == CNT_LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      // a timeout in the same cycle as err_clr must still be reported
      r_err <= (w_to_hit & ~i_done) | (r_err & ~i_err_clr);
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (i_slow & ~i_done) r_state <= WAIT;
      end else begin
        r_cnt <= (r_cnt == CNT_LAST) ? r_cnt : r_cnt + 1'b1;
        if (i_done | w_to_hit) r_state <= IDLE;
      end
    end
  assign o_pstall      = w_wait ? (~i_done & ~w_to_hit) : (i_slow & ~i_done);
  assign o_busy        = w_wait;
  assign o_timeout_err = r_err;
endmodule

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq: RV32I 5-stage hazard unit with forwarding, load-use and slow-peripheral stalls
module hazard_ctrl_seq
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int PERIPH_W = 4,
  parameter logic [PERIPH_W-1:0] SLOW_ID = PERIPH_W'(SLOW_ID_DEF),
  parameter bit STORE_BLOCK = 1'b1,
  parameter int TO_W = 16,
  parameter logic [TO_W-1:0] TO_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              load_e,
  input  logic              pc_src_e,
  input  logic              periph_req,
  input  logic [PERIPH_W-1:0] periph_sel,
  input  logic              periph_store,
  input  logic              periph_done,
  input  logic              err_clr,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              periph_busy,
  output logic              timeout_err
);
  logic w_lw_stall, w_slow, w_pstall;
  assign fwd_a_e = (rs1_e != '0 && rs1_e == rd_m && reg_write_m) ? FWD_MEM :
                   (rs1_e != '0 && rs1_e == rd_w && reg_write_w) ? FWD_WB : FWD_RF;
  assign fwd_b_e = (rs2_e != '0 && rs2_e == rd_m && reg_write_m) ? FWD_MEM :
                   (rs2_e != '0 && rs2_e == rd_w && reg_write_w) ? FWD_WB : FWD_RF;
  assign w_lw_stall = load_e & (rd_e != '0) & ((rs1_d == rd_e) | (rs2_d == rd_e));
  assign w_slow = periph_req & (periph_sel == SLOW_ID) & (~periph_store | STORE_BLOCK);
  periph_wait_fsm #(.TO_W(TO_W), .TO_MAX(TO_MAX)) u_wait (
    .clk(clk), .rst_n(rst_n), .i_slow(w_slow), .i_done(periph_done), .i_err_clr(err_clr),
    .o_pstall(w_pstall), .o_busy(periph_busy), .o_timeout_err(timeout_err)
  );
  assign stall_e = w_pstall;
  assign stall_m = w_pstall;
  assign stall_w = w_pstall;
  assign stall_f = w_pstall | w_lw_stall;
  assign stall_d = w_pstall | w_lw_stall;
  // a frozen back end holds the Execute instruction instead of flushing it
  assign flush_d = pc_src_e & ~w_pstall;
  assign flush_e = (pc_src_e | w_lw_stall) & ~w_pstall;
endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// tb_hazard_ctrl_seq: table-driven checks of forwarding/load-use plus directed peripheral wait sequences
module tb_hazard_ctrl_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_m, reg_write_w, load_e, pc_src_e, periph_req, periph_store, periph_done, err_clr;
  logic [3:0] periph_sel;
  logic [1:0] fwd_a_e, fwd_b_e, p_fa, p_fb;
  logic flush_d, flush_e, stall_f, stall_d, stall_e, stall_m, stall_w, periph_busy, timeout_err;
  logic p_fd, p_fe, p_sf, p_sd, p_se, p_sm, p_sw, p_busy, p_err;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl_seq #(.STORE_BLOCK(1'b1), .TO_MAX(16'd8)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .periph_req(periph_req), .periph_sel(periph_sel),
    .periph_store(periph_store), .periph_done(periph_done), .err_clr(err_clr),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .flush_d(flush_d), .flush_e(flush_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .periph_busy(periph_busy), .timeout_err(timeout_err)
  );

  hazard_ctrl_seq #(.STORE_BLOCK(1'b0), .TO_MAX(16'd8)) dut_post (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .periph_req(periph_req), .periph_sel(periph_sel),
    .periph_store(periph_store), .periph_done(periph_done), .err_clr(err_clr),
    .fwd_a_e(p_fa), .fwd_b_e(p_fb), .flush_d(p_fd), .flush_e(p_fe),
    .stall_f(p_sf), .stall_d(p_sd), .stall_e(p_se), .stall_m(p_sm), .stall_w(p_sw),
    .periph_busy(p_busy), .timeout_err(p_err)
  );

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic wm, ww, ld, pc;
    logic [10:0] exp;
  } vec_t;
  vec_t v[12];

  logic [4:0] w_st;
  assign w_st = {stall_f, stall_d, stall_e, stall_m, stall_w};

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {reg_write_m, reg_write_w, load_e, pc_src_e} = '0;
    {periph_req, periph_store, periph_done, err_clr} = '0;
    periph_sel = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // fields: rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w wm ww ld pc ; exp = {fa,fb,sf,sd,se,sm,sw,fd,fe}
    v[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_00000_00};
    v[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 11'b10_00_00000_00};
    v[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 11'b00_00_00000_00};
    v[3]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 11'b01_00_00000_00};
    v[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 11'b00_01_00000_00};
    v[5]  = '{5'd0, 5'd0, 5'd4, 5'd6, 5'd0, 5'd6, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 11'b01_10_00000_00};
    v[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_00_11000_01};
    v[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_00_00000_00};
    v[8]  = '{5'd7, 5'd3, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11'b00_00_11000_01};
    v[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00_00_00000_00};
    v[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 11'b00_00_00000_11};
    v[11] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 11'b00_00_11000_11};
    idle();
    #12;
    chk("reset_outputs", {3'b0, fwd_a_e, fwd_b_e, w_st, flush_d, flush_e, periph_busy, timeout_err}, 16'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} =
        {v[i].rs1_d, v[i].rs2_d, v[i].rs1_e, v[i].rs2_e, v[i].rd_e, v[i].rd_m, v[i].rd_w};
      {reg_write_m, reg_write_w, load_e, pc_src_e} = {v[i].wm, v[i].ww, v[i].ld, v[i].pc};
      #2;
      chk($sformatf("vec%0d", i), {5'b0, fwd_a_e, fwd_b_e, w_st, flush_d, flush_e}, {5'b0, v[i].exp});
    end
    // slow load completing on cycle 5, with a branch pending throughout
    cyc(); idle();
    periph_req = 1'b1; periph_sel = 4'd2; pc_src_e = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #2;
      chk($sformatf("wait_c%0d", c), {8'b0, w_st, flush_d, flush_e, periph_busy},
          {8'b0, 5'b11111, 2'b00, (c > 1) ? 1'b1 : 1'b0});
      cyc();
    end
    periph_done = 1'b1;
    #2;
    chk("done_release", {11'b0, w_st}, 16'h0);
    cyc();
    periph_req = 1'b0; periph_done = 1'b0;
    #2;
    chk("after_done", {12'b0, periph_busy, flush_d, flush_e, stall_e}, 16'b0000_0000_0000_0110);
    // timeout with no completion
    cyc(); idle();
    periph_req = 1'b1; periph_sel = 4'd2;
    for (int c = 1; c <= 8; c++) begin
      #2;
      chk($sformatf("to_stall_c%0d", c), {10'b0, w_st, timeout_err}, {10'b0, 5'b11111, 1'b0});
      cyc();
    end
    #2;
    chk("to_release", {10'b0, w_st, timeout_err}, 16'h0);
    cyc();
    periph_req = 1'b0;
    #2;
    chk("to_err_set", {13'b0, periph_busy, timeout_err, stall_e}, 16'b010);
    cyc(); cyc();
    #2;
    chk("to_err_held", {15'b0, timeout_err}, 16'h1);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    #2;
    chk("err_cleared", {15'b0, timeout_err}, 16'h0);
    // slow store: blocked instance stalls, posted instance does not
    cyc();
    periph_req = 1'b1; periph_sel = 4'd2; periph_store = 1'b1;
    #2;
    chk("store_blocked", {11'b0, w_st}, 16'h1F);
    chk("store_posted", {11'b0, p_sf, p_sd, p_se, p_sm, p_sw}, 16'h0);
    cyc();
    periph_req = 1'b0; periph_store = 1'b0; periph_done = 1'b1;
    #2;
    chk("store_done", {11'b0, w_st}, 16'h0);
    // non-slow peripheral and zero-wait completion
    cyc(); idle();
    periph_req = 1'b1; periph_sel = 4'd3;
    #2;
    chk("other_periph", {11'b0, w_st}, 16'h0);
    cyc();
    periph_sel = 4'd2; periph_done = 1'b1;
    #2;
    chk("zero_wait", {11'b0, w_st}, 16'h0);
    cyc(); idle();
    #2;
    chk("zero_wait_idle", {14'b0, periph_busy, stall_e}, 16'h0);
    // async reset in the middle of WAIT
    periph_req = 1'b1; periph_sel = 4'd2;
    cyc();
    periph_req = 1'b0;
    #2;
    chk("mid_wait", {10'b0, periph_busy, w_st}, 16'h3F);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {10'b0, periph_busy, w_st}, 16'h0);
    cyc();
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
